// File: rtl/uart_num_entry.sv
// UART executor for the WaitUARTMsg / SendUARTNewLn macro commands: collects a CR-terminated
// hex number with echo, or emits CR LF, then pulses done back to the macro FSM.
module uart_num_entry #(
    parameter logic [3:0]  WAIT_CODE  = 4'h5,
    parameter logic [3:0]  NEWLN_CODE = 4'h4,
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  macro_states,
    input  logic        macro_states_valid,
    output logic        uart_macro_states_done,
    output logic [31:0] rx_num,
    output logic [3:0]  rx_digits,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        echo_ovf
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    typedef enum logic [2:0] {IDLE, RXNUM, NL_CR, NL_LF, DONE} state_t;

    state_t      state_q;
    logic [31:0] acc_q;
    logic [3:0]  cnt_q;
    logic [31:0] rx_num_q;
    logic [3:0]  rx_digits_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        done_q;
    logic        ovf_q;

    logic        is_hex;
    logic [3:0]  nibble;
    logic        tx_hs;
    logic [3:0]  cnt_d;

    always_comb begin
        is_hex = 1'b0;
        nibble = '0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = 4'(rx_data - 8'h30);
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_hex = 1'b1;
            nibble = 4'(rx_data - 8'h37);
        end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_hex = 1'b1;
            nibble = 4'(rx_data - 8'h57);
        end
    end

    assign tx_hs = tx_valid_q & tx_ready;
    assign cnt_d = (cnt_q < MAX_CNT) ? cnt_q + 4'd1 : cnt_q;

    // tx_data_q/tx_valid_q double as the 1-deep echo buffer and the CR/LF output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            rx_num_q    <= '0;
            rx_digits_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (macro_states_valid && macro_states == WAIT_CODE) begin
                        state_q <= RXNUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end else if (macro_states_valid && macro_states == NEWLN_CODE) begin
                        state_q    <= NL_CR;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= 8'h0D;
                    end
                end
                RXNUM: begin
                    if (tx_hs) begin
                        tx_valid_q <= 1'b0;
                    end
                    if (rx_valid) begin
                        if (is_hex) begin
                            acc_q <= {acc_q[27:0], nibble};
                            cnt_q <= cnt_d;
                            // A buffer being accepted this cycle counts as free.
                            if (tx_valid_q && !tx_ready) begin
                                ovf_q <= 1'b1;
                            end else begin
                                tx_data_q  <= rx_data;
                                tx_valid_q <= 1'b1;
                            end
                        end else if (rx_data == 8'h0D) begin
                            rx_num_q    <= acc_q;
                            rx_digits_q <= cnt_q;
                            state_q     <= DONE;
                            done_q      <= !tx_valid_q || tx_ready;
                        end
                    end
                end
                NL_CR: begin
                    if (tx_ready) begin
                        state_q   <= NL_LF;
                        tx_data_q <= 8'h0A;
                    end
                end
                NL_LF: begin
                    if (tx_ready) begin
                        state_q    <= DONE;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                DONE: begin
                    // done_q low here means a pending echo is still draining.
                    if (done_q) begin
                        state_q <= IDLE;
                    end else if (!tx_valid_q || tx_ready) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_macro_states_done = done_q;
    assign rx_num                 = rx_num_q;
    assign rx_digits              = rx_digits_q;
    assign tx_data                = tx_data_q;
    assign tx_valid               = tx_valid_q;
    assign echo_ovf               = ovf_q;

endmodule

// File: tb/tb_uart_num_entry.sv
// Scoreboard bench for uart_num_entry: directed macro scenarios plus randomized number entry
// checked against a digit-string reference model.
module tb_uart_num_entry;

    localparam logic [3:0] WAIT_C  = 4'h5;
    localparam logic [3:0] NEWLN_C = 4'h4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  macro_states;
    logic        macro_states_valid;
    logic        done;
    logic [31:0] rx_num;
    logic [3:0]  rx_digits;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        echo_ovf;

    uart_num_entry #(.WAIT_CODE(WAIT_C), .NEWLN_CODE(NEWLN_C), .MAX_DIGITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .macro_states(macro_states), .macro_states_valid(macro_states_valid),
        .uart_macro_states_done(done), .rx_num(rx_num), .rx_digits(rx_digits),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .echo_ovf(echo_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] num;
        logic [3:0]  dig;
        logic        ovf;
    } res_t;

    logic [7:0] exp_tx[$];
    res_t       exp_done[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model: the number is the value of the hex digits typed so far, mod 2^32.
    logic [31:0] m_acc;
    int          m_cnt;
    logic        m_ovf;
    logic [31:0] last_num;
    logic [3:0]  last_dig;

    bit rdy_rand  = 1'b0;
    bit rdy_fixed = 1'b1;

    always @(posedge clk) begin
        #1;
        tx_ready = rdy_rand ? 1'($urandom % 2) : rdy_fixed;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic bit hexchar(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b <= "9") return int'(b) - 48;
        if (b <= "F") return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT hands over a byte or signals done.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    logic       prev_done  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected actual=%h required=none", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
            end
            if (done) begin
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_unexpected actual=1 required=0");
                end else begin
                    res_t r;
                    r = exp_done.pop_front();
                    check("rx_num", rx_num, r.num);
                    check("rx_digits", {28'd0, rx_digits}, {28'd0, r.dig});
                    check("echo_ovf", {31'd0, echo_ovf}, {31'd0, r.ovf});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_done  = done;
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] code);
        macro_states       = code;
        macro_states_valid = 1'b1;
        tick();
        macro_states_valid = 1'b0;
        macro_states       = '0;
    endtask

    task automatic start_wait();
        cmd(WAIT_C);
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic newline();
        res_t r;
        cmd(NEWLN_C);
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
        r.num = last_num; r.dig = last_dig; r.ovf = m_ovf;
        exp_done.push_back(r);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit echoed);
        if (hexchar(b)) begin
            m_acc = m_acc * 16 + 32'(hexval(b));
            if (m_cnt < 8) m_cnt++;
            if (echoed) exp_tx.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic send_cr();
        res_t r;
        send_byte(8'h0D);
        last_num = m_acc;
        last_dig = 4'(m_cnt);
        r.num = last_num; r.dig = last_dig; r.ovf = m_ovf;
        exp_done.push_back(r);
    endtask

    task automatic drain();
        int g = 0;
        while (tx_valid && g < 200) begin
            tick();
            g++;
        end
        if (g >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout actual=tx_valid required=idle");
        end
    endtask

    task automatic wait_done();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 300);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            if (hexchar(c)) drain();
            send_byte(c);
            model_byte(c, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; macro_states = '0; macro_states_valid = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        m_acc = '0; m_cnt = 0; m_ovf = 1'b0; last_num = '0; last_dig = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {done, tx_valid, echo_ovf, tx_data, rx_digits},
              {1'b0, 1'b0, 1'b0, 8'h00, 4'h0});
        check("rst_rx_num", rx_num, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: basic entry, done one cycle after CR with an empty echo buffer
        rdy_fixed = 1'b1;
        start_wait();
        send_str("1A2b");
        repeat (3) tick();
        send_cr();
        @(negedge clk);
        check("t1_latency", {31'd0, done}, 32'd1);
        tick();
        check("t1_num", rx_num, 32'h0000_1A2B);
        check("t1_digits", {28'd0, rx_digits}, 32'd4);

        // 2: nine digits keep only the last eight
        start_wait();
        send_str("123456789");
        send_cr();
        wait_done();
        check("t2_num", rx_num, 32'h2345_6789);
        check("t2_digits", {28'd0, rx_digits}, 32'd8);

        // 3: CR LF under backpressure; number outputs untouched
        rdy_fixed = 1'b0;
        tick();
        newline();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_cr_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h0D});
        end
        rdy_fixed = 1'b1;
        begin
            int g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!(tx_valid && tx_ready && tx_data == 8'h0A) && g < 50);
        end
        @(negedge clk);
        check("t3_done_after_lf", {31'd0, done}, 32'd1);
        tick();
        check("t3_num_kept", rx_num, 32'h2345_6789);

        // 4: junk discarded; done waits for the pending echo
        rdy_fixed = 1'b0;
        tick();
        start_wait();
        send_str("G 4");
        send_cr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_done_held", {31'd0, done}, 32'd0);
        end
        tick();
        rdy_fixed = 1'b1;
        wait_done();
        check("t4_num", rx_num, 32'd4);

        // 5: second digit while the echo buffer is full is counted but not echoed
        rdy_fixed = 1'b0;
        tick();
        start_wait();
        send_byte("1"); model_byte("1", 1'b1);
        send_byte("2"); model_byte("2", 1'b0);
        @(negedge clk);
        check("t5_ovf", {31'd0, echo_ovf}, 32'd1);
        tick();
        send_cr();
        rdy_fixed = 1'b1;
        wait_done();
        check("t5_num", rx_num, 32'h12);

        // 6: reset mid-entry drops the partial number
        start_wait();
        send_byte("7"); model_byte("7", 1'b1);
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_num", rx_num, 32'd0);
        check("t6_rst_ctl", {29'd0, done, tx_valid, echo_ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        last_num = '0; last_dig = '0; m_ovf = 1'b0;
        tick();
        start_wait();
        send_cr();
        wait_done();
        check("t6_num", rx_num, 32'd0);

        // Randomized traffic with random tx_ready
        rdy_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [3:0] oc;
            oc = 4'($urandom_range(0, 15));
            if (oc != WAIT_C && oc != NEWLN_C) cmd(oc);
            send_byte("5");
            if ($urandom % 4 == 0) begin
                newline();
                wait_done();
            end else begin
                int n;
                start_wait();
                n = $urandom_range(0, 12);
                for (int k = 0; k < n; k++) begin
                    logic [7:0] c;
                    case ($urandom % 4)
                        0: c = 8'($urandom_range(48, 57));
                        1: c = 8'($urandom_range(65, 70));
                        2: c = 8'($urandom_range(97, 102));
                        default: begin
                            c = 8'($urandom_range(0, 255));
                            if (hexchar(c) || c == 8'h0D) c = 8'h7E;
                        end
                    endcase
                    if (hexchar(c)) drain();
                    send_byte(c);
                    model_byte(c, 1'b1);
                    if ($urandom % 8 == 0) cmd(NEWLN_C);
                    repeat ($urandom_range(0, 2)) tick();
                end
                send_cr();
                wait_done();
            end
        end
        rdy_rand = 1'b0;
        repeat (5) tick();
        check("sb_tx_empty", exp_tx.size(), 32'd0);
        check("sb_done_empty", exp_done.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
